note_player: RTL
================

Name: note_player

Overview:
- Consumer end of the song-reader note handshake.
- Accepts one note (pitch + duration) per new_note pulse from song_reader and times it in beat ticks.
- While a note is held, drives a phase-increment (step_size) to the downstream sine/sample generator.
- Pulses note_done when the duration expires so song_reader can issue the next note.

Parameters:
- STEP_W, 20, width of step_size / phase increment.
- NOTE_W, 6, width of note code (0 = rest, 1..63 = semitones, 49 = A4).
- DUR_W, 6, width of duration in beats.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- play_enable  input  1  1 = playing; 0 = paused/silenced.
- new_note  input  1  one-cycle pulse; note and duration are valid in this cycle.
- note  input  NOTE_W  pitch code of the incoming note.
- duration  input  DUR_W  length of the incoming note in beats.
- beat  input  1  one-cycle tick per beat (48 Hz strobe from the beat generator).
- step_size  output  STEP_W  phase increment for the sample generator; 0 = silence.
- note_done  output  1  one-cycle pulse when the current note's duration has expired.
- busy  output  1  1 while a note is being timed.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; dur_cnt=0; cur_note=0.
  - step_size=0, note_done=0, busy=0.
  - An in-flight note is abandoned; no note_done is issued for it.
- States: IDLE, PLAYING. busy is 1 exactly in PLAYING.
- Loading a note:
  - new_note=1 in any state: next edge latches cur_note=note and dur_cnt=duration, and enters PLAYING.
  - step_size = freq_rom(cur_note), valid 1 cycle after the new_note cycle.
  - A new_note while PLAYING overrides the current note; no note_done is issued for the overridden note.
- PLAYING with play_enable=1: each beat=1 cycle decrements dur_cnt.
  - When beat=1 and dur_cnt==1: note_done=1 for the following cycle, dur_cnt goes to 0, state goes to IDLE.
  - step_size stays at the note value through the note_done cycle, then becomes 0.
- duration==0: treated as an immediate expiry. note_done pulses in the cycle after the load, independent of beat; state returns to IDLE.
- play_enable=0:
  - dur_cnt is frozen; beat is ignored; step_size is forced to 0 (combinational gate on the registered value).
  - new_note is still latched.
  - Returning play_enable to 1 resumes the count with no lost beats.
- new_note and beat in the same cycle: new_note wins. The load takes the fresh duration, and that beat is not applied to it.
- Rest: note==0 gives step_size=0 while still timing the duration and pulsing note_done normally.
- note_done:
  - Registered; never asserted for more than 1 cycle.
  - Never asserted in the same cycle as a load.
- Width rules:
  - dur_cnt is DUR_W bits and never underflows; decrement happens only when dur_cnt>0.
  - freq_rom output is exactly STEP_W bits, unsigned.
- freq_rom table: step(n) = round(440 * 2^((n-49)/12) * 2^20 / 48000) for n=1..63; step(0)=0.
  - Reference points: note 49 -> 9612, note 37 -> 4806, note 61 -> 19224.

Decomposition:
- Shared package/header (also used by song_reader):
  - NOTE_W, DUR_W, STEP_W.
  - State encodings IDLE=1'b0, PLAYING=1'b1.
  - REST_NOTE=0.
- One sub-module: note_freq_rom (combinational case table, note -> step_size).
- FSM and counter stay in note_player.

Test Plan:
- Reset then new_note with note=49, duration=3, play_enable=1; beats every 10 cycles -> step_size=9612 one cycle after load; note_done pulses once, the cycle after the 3rd beat; then busy=0 and step_size=0.
- duration=0, note=37 -> note_done pulses the cycle after load with no beat needed; step_size=4806 for exactly that cycle.
- note=61, duration=4; drop play_enable after 2 beats for 5 beats, then restore -> step_size=0 while paused; note_done only after 2 further beats (4 counted total).
- new_note (note=49, duration=2) coinciding with a beat; then a second new_note (note=0, duration=1) mid-note -> first note yields no note_done; rest gives step_size=0; note_done after 1 beat.
- reset asserted while PLAYING with dur_cnt=2 -> outputs immediately 0; no note_done after release; next new_note plays normally.
- Loop with a song_reader model issuing new_note 1 cycle after each note_done, 29 notes -> exactly 29 note_done pulses, each 1 cycle wide.

Source files
------------

// File: rtl/note_player_pkg.sv
// note_player_pkg: constants and state encoding shared by the note
// handshake between song_reader and note_player.
//   NOTE_W    : width of a note code (0 = rest, 49 = A4)
//   DUR_W     : width of a duration in beats
//   STEP_W    : width of the phase increment sent to the sample generator
//   REST_NOTE : note code that plays silence but is still timed
package note_player_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int STEP_W = 20;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } np_state_e;

endpackage

// File: rtl/note_freq_rom.sv
// note_freq_rom: combinational note -> phase-increment table.
//   note_i : note code (0 = rest)
//   step_o : round(440 * 2^((n-49)/12) * 2^20 / 48000), 0 for a rest
module note_freq_rom
    import note_player_pkg::*;
(
    input  logic [NOTE_W-1:0] note_i,
    output logic [STEP_W-1:0] step_o
);

    always_comb begin
        step_o = '0;
        case (note_i)
            6'd1:  step_o = STEP_W'(601);
            6'd2:  step_o = STEP_W'(636);
            6'd3:  step_o = STEP_W'(674);
            6'd4:  step_o = STEP_W'(714);
            6'd5:  step_o = STEP_W'(757);
            6'd6:  step_o = STEP_W'(802);
            6'd7:  step_o = STEP_W'(850);
            6'd8:  step_o = STEP_W'(900);
            6'd9:  step_o = STEP_W'(954);
            6'd10: step_o = STEP_W'(1010);
            6'd11: step_o = STEP_W'(1070);
            6'd12: step_o = STEP_W'(1134);
            6'd13: step_o = STEP_W'(1201);
            6'd14: step_o = STEP_W'(1273);
            6'd15: step_o = STEP_W'(1349);
            6'd16: step_o = STEP_W'(1429);
            6'd17: step_o = STEP_W'(1514);
            6'd18: step_o = STEP_W'(1604);
            6'd19: step_o = STEP_W'(1699);
            6'd20: step_o = STEP_W'(1800);
            6'd21: step_o = STEP_W'(1907);
            6'd22: step_o = STEP_W'(2021);
            6'd23: step_o = STEP_W'(2141);
            6'd24: step_o = STEP_W'(2268);
            6'd25: step_o = STEP_W'(2403);
            6'd26: step_o = STEP_W'(2546);
            6'd27: step_o = STEP_W'(2697);
            6'd28: step_o = STEP_W'(2858);
            6'd29: step_o = STEP_W'(3028);
            6'd30: step_o = STEP_W'(3208);
            6'd31: step_o = STEP_W'(3398);
            6'd32: step_o = STEP_W'(3600);
            6'd33: step_o = STEP_W'(3815);
            6'd34: step_o = STEP_W'(4041);
            6'd35: step_o = STEP_W'(4282);
            6'd36: step_o = STEP_W'(4536);
            6'd37: step_o = STEP_W'(4806);
            6'd38: step_o = STEP_W'(5092);
            6'd39: step_o = STEP_W'(5395);
            6'd40: step_o = STEP_W'(5715);
            6'd41: step_o = STEP_W'(6055);
            6'd42: step_o = STEP_W'(6415);
            6'd43: step_o = STEP_W'(6797);
            6'd44: step_o = STEP_W'(7201);
            6'd45: step_o = STEP_W'(7629);
            6'd46: step_o = STEP_W'(8083);
            6'd47: step_o = STEP_W'(8563);
            6'd48: step_o = STEP_W'(9072);
            6'd49: step_o = STEP_W'(9612);
            6'd50: step_o = STEP_W'(10184);
            6'd51: step_o = STEP_W'(10789);
            6'd52: step_o = STEP_W'(11431);
            6'd53: step_o = STEP_W'(12110);
            6'd54: step_o = STEP_W'(12830);
            6'd55: step_o = STEP_W'(13593);
            6'd56: step_o = STEP_W'(14402);
            6'd57: step_o = STEP_W'(15258);
            6'd58: step_o = STEP_W'(16165);
            6'd59: step_o = STEP_W'(17127);
            6'd60: step_o = STEP_W'(18145);
            6'd61: step_o = STEP_W'(19224);
            6'd62: step_o = STEP_W'(20367);
            6'd63: step_o = STEP_W'(21578);
            default: step_o = '0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// note_player: times one note at a time in beat ticks and drives its
// phase increment to the sample generator.
//   clk_i         : system clock
//   reset_i       : asynchronous active-low reset
//   play_enable_i : 1 = playing, 0 = paused (count frozen, output silenced)
//   new_note_i    : one-cycle load strobe for note_i / duration_i
//   note_i        : pitch code of the incoming note
//   duration_i    : length of the incoming note in beats
//   beat_i        : one-cycle beat tick
//   step_size_o   : phase increment, 0 = silence
//   note_done_o   : one-cycle pulse when the current note expires
//   busy_o        : 1 while a note is being timed
//
// state   | meaning
// IDLE    | no note held; waiting for new_note
// PLAYING | note held; dur_cnt counts down on beats
module note_player
    import note_player_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              play_enable_i,
    input  logic              new_note_i,
    input  logic [NOTE_W-1:0] note_i,
    input  logic [DUR_W-1:0]  duration_i,
    input  logic              beat_i,
    output logic [STEP_W-1:0] step_size_o,
    output logic              note_done_o,
    output logic              busy_o
);

    np_state_e         state_q, state_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;
    logic              note_done_q, note_done_d;
    logic [STEP_W-1:0] rom_step;

    note_freq_rom u_rom (
        .note_i (cur_note_q),
        .step_o (rom_step)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            dur_cnt_q   <= '0;
            cur_note_q  <= REST_NOTE;
            note_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dur_cnt_q   <= dur_cnt_d;
            cur_note_q  <= cur_note_d;
            note_done_q <= note_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dur_cnt_d   = dur_cnt_q;
        cur_note_d  = cur_note_q;
        note_done_d = 1'b0;
        if (new_note_i) begin
            // A load wins over a same-cycle beat; a zero-length note
            // reports done straight away while PLAYING for one cycle.
            state_d     = PLAYING;
            cur_note_d  = note_i;
            dur_cnt_d   = duration_i;
            note_done_d = (duration_i == '0);
        end else if (state_q == PLAYING) begin
            if (dur_cnt_q == '0) begin
                // Only reachable after a zero-length load; done already pulsed.
                state_d = IDLE;
            end else if (play_enable_i && beat_i) begin
                dur_cnt_d = dur_cnt_q - DUR_W'(1);
                if (dur_cnt_q == DUR_W'(1)) begin
                    note_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        end
    end

    // The note keeps sounding through its note_done cycle.
    always_comb begin
        busy_o      = (state_q == PLAYING);
        note_done_o = note_done_q;
        step_size_o = '0;
        if (play_enable_i && ((state_q == PLAYING) || note_done_q)) begin
            step_size_o = rom_step;
        end
    end

endmodule
